pipe_commit_monitor: RTL and testbench
======================================

// Module: pipe_commit_monitor
// PURPOSE
//   Parametrised instruction-tracking monitor for refinement checking of a stalling in-order
//   pipeline (e.g. L2 pipe1/pipe2). Issues one tracked token, follows it through NUM_STAGES
//   stall-gated stages, and flags commit, first/second end and timeout for property checks.
//   Generalises the fixed 3/4-stage hand-written monitors: any depth, S1 entry qualifier,
//   sticky timeout, per-stage visibility.
// PARAMETERS
//   NUM_STAGES  4    pipeline stages tracked (S1..SN), >=2
//   CNT_W       8    cycle counter width
//   CNT_SAT     132  counter saturation value (< 2**CNT_W)
//   MAX_CYCLES  50   last cycle_cnt value at which commit counts as in-bound end
// PORTS
//   clk          in   1           clock
//   rst          in   1           synchronous reset, active-high
//   issue        in   1           request to start tracking
//   s1_accept    in   1           S1 entry qualifier (valid_S1 & !stall_S1); tie 1 if unused
//   stall        in   NUM_STAGES  stall[i] = stall of stage S(i+1); stall[0] unused
//   start        out  1           one-cycle start pulse (token injected into S1)
//   started      out  1           sticky: start has occurred
//   cycle_cnt    out  CNT_W       cycles since start, saturating
//   stage_tok    out  NUM_STAGES  token-present vector, bit i = token in S(i+1)
//   commit       out  1           token left SN (registered)
//   iend         out  1           combinational first-end condition
//   ended        out  1           sticky: first in-bound commit seen
//   second_ended out  1           sticky: commit seen again after ended
//   timeout      out  1           sticky: started, not ended, cycle_cnt > MAX_CYCLES
// BEHAVIOUR
//   - Reset: start, started, cycle_cnt, all stage regs, commit, ended, second_ended, timeout = 0.
//     rst mid-operation discards in-flight token on the same edge; no partial state survives.
//   - start: if (start|started) -> 0; else if issue -> 1. At most one pulse per reset epoch.
//   - started <= 1 on cycle after start=1.
//   - cycle_cnt: +1 per cycle while (start|started) and cycle_cnt < CNT_SAT; holds at CNT_SAT.
//   - Stage chain: tok[0] = start & s1_accept (combinational). For i=1..N-1:
//     tok_f[i] <= tok_next[i-1] when !stall[i], else hold; tok[i] = tok_f[i];
//     tok_next[i] = tok[i] & !stall[i]; tok_next[0] = tok[0].
//     commit <= tok_next[N-1] (not stall-gated). Latency with no stalls: start -> commit = N cycles.
//   - Token is never duplicated: a stalled stage holds it, downstream sees 0.
//   - iend = commit & started & !ended & (cycle_cnt <= MAX_CYCLES); ended <= 1 when iend.
//   - second_ended <= 1 when ended & commit & started & !second_ended.
//   - timeout <= 1 when started & !ended & cycle_cnt > MAX_CYCLES; a later commit does not set
//     ended and does not clear timeout. ended and timeout are mutually exclusive.
//   - s1_accept=0 during start: token is lost, commit never fires, timeout fires at MAX_CYCLES+1.
// CONFIGURATION
//   PCM_FLUSH_EN defined: extra input port 'flush' (1 bit). flush=1 clears all tok_f and commit
//     on the next edge (priority over stall/advance); start/started/cycle_cnt/sticky flags kept;
//     tok[0] is forced 0 that cycle. Without it: no flush port, tokens only leave via commit/rst.
// TESTING
//   N=4, no stalls, issue=1 @c0 -> start @c1, commit @c5, iend/ended=1 @c5/c6, cycle_cnt=4 @c5.
//   stall[2]=1 for 3 cycles while token in S3 -> stage_tok=4'b0100 held 3 cycles, commit 3 later.
//   stall[3] held 60 cycles -> timeout=1 when cycle_cnt=51, ended stays 0 after late commit.
//   s1_accept=0 at start -> stage_tok stays 0, no commit, timeout=1; cycle_cnt saturates at 132.
//   rst pulsed with token in S2 -> next cycle all outputs 0; new issue restarts full sequence.
//   PCM_FLUSH_EN, flush with token in S3 -> stage_tok=0 next cycle, no commit, started still 1.

Source files
------------

// File: rtl/pipe_commit_monitor.sv
// -----------------------------------------------------------------------------
// pipe_commit_monitor
//   Instruction-tracking monitor for refinement checking of a stalling in-order
//   pipeline. It injects exactly one token per reset epoch and follows it through
//   NUM_STAGES stall-gated stages. It flags the commit, the first in-bound end,
//   any second end, and a sticky timeout for use by property checks.
//
//   Optional feature (compile-time macro PCM_FLUSH_EN):
//     Adds a 1-bit 'flush' input. When flush is high, every in-flight token
//     and any pending commit are dropped on the next edge. The epoch
//     bookkeeping (start/started/cycle_cnt/sticky flags) is kept.
//     Without the macro there is no flush port, and a token leaves the chain
//     only through commit or rst.
// -----------------------------------------------------------------------------
module pipe_commit_monitor #(
  parameter int NUM_STAGES = 4,
  parameter int CNT_W      = 8,
  parameter int CNT_SAT    = 132,
  parameter int MAX_CYCLES = 50
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue,
  input  logic                  s1_accept,
  input  logic [NUM_STAGES-1:0] stall,
`ifdef PCM_FLUSH_EN
  input  logic                  flush,
`endif
  output logic                  start,
  output logic                  started,
  output logic [CNT_W-1:0]      cycle_cnt,
  output logic [NUM_STAGES-1:0] stage_tok,
  output logic                  commit,
  output logic                  iend,
  output logic                  ended,
  output logic                  second_ended,
  output logic                  timeout
);

  localparam logic [CNT_W-1:0] SAT_V = CNT_W'(CNT_SAT);
  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_CYCLES);

  // S1 is purely combinational (start & s1_accept), so it has no register.
  logic [NUM_STAGES-1:1] tok_f;
  logic [NUM_STAGES-1:0] tok;
  logic [NUM_STAGES-1:0] tok_next;
  logic                  flush_c;
  logic                  active;
  logic                  over_bound;

  // stall[0] has no effect: S1 is never held, only qualified by s1_accept.
  logic unused_stall0;
  assign unused_stall0 = stall[0];

`ifdef PCM_FLUSH_EN
  assign flush_c = flush;
`else
  assign flush_c = 1'b0;
`endif

  assign active     = start | started;
  assign over_bound = (cycle_cnt > MAX_V);

  // Token presence and stall-gated hand-off values for every stage.
  always_comb begin
    // NOTE: every output of this block is assigned before any condition is
    // applied. This ensures no path leaves a value unset, so no latch is inferred.
    tok      = '0;
    tok_next = '0;
    tok[0]   = start & s1_accept & ~flush_c;
    for (int i = 1; i < NUM_STAGES; i++) begin
      tok[i] = tok_f[i];
    end
    tok_next[0] = tok[0];
    for (int i = 1; i < NUM_STAGES; i++) begin
      tok_next[i] = tok[i] & ~stall[i];
    end
  end

  assign stage_tok = tok;

  // Stage registers: a stalled stage holds its token, a free stage takes its
  // predecessor's hand-off. A flush drops everything, overriding stall/advance.
  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments. All stages then sample
    // the pre-edge values of their neighbours, which gives a true one-hop shift.
    if (rst) begin
      // NOTE: the stage chain is a handful of flops, not a memory. It is
      // cleared on reset so that no token from a previous epoch survives.
      tok_f  <= '0;
      commit <= 1'b0;
    end else if (flush_c) begin
      tok_f  <= '0;
      commit <= 1'b0;
    end else begin
      for (int i = 1; i < NUM_STAGES; i++) begin
        if (!stall[i]) begin
          tok_f[i] <= tok_next[i-1];
        end
      end
      commit <= tok_next[NUM_STAGES-1];
    end
  end

  // Epoch control: a single start pulse, the sticky started flag and the
  // saturating cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      start     <= 1'b0;
      started   <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      start   <= active ? 1'b0 : issue;
      started <= started | start;
      if (active && (cycle_cnt < SAT_V)) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
    end
  end

  // First-end condition: the commit is seen while still inside the cycle bound.
  assign iend = commit & started & ~ended & (cycle_cnt <= MAX_V);

  // Sticky verdict flags. Once the bound has passed without an end, timeout
  // latches; a late commit can no longer produce ended.
  always_ff @(posedge clk) begin
    if (rst) begin
      ended        <= 1'b0;
      second_ended <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      if (iend) begin
        ended <= 1'b1;
      end
      if (ended && commit && started && !second_ended) begin
        second_ended <= 1'b1;
      end
      if (started && !ended && over_bound) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_commit_monitor.sv
// -----------------------------------------------------------------------------
// tb_pipe_commit_monitor
//   Self-checking bench for pipe_commit_monitor (NUM_STAGES=4, MAX_CYCLES=50,
//   CNT_SAT=132). A position-based token model predicts the outputs of every
//   cycle. Each prediction is queued when the stimulus is driven and popped
//   when the DUT outputs are sampled. Directed anchors check commit latency,
//   stall delay, timeout, saturation and reset.
// -----------------------------------------------------------------------------
module tb_pipe_commit_monitor;

  localparam int N   = 4;
  localparam int MAX = 50;
  localparam int SAT = 132;

  logic         clk = 1'b0;
  logic         rst;
  logic         issue;
  logic         s1_accept;
  logic [N-1:0] stall;
`ifdef PCM_FLUSH_EN
  logic         flush;
`endif
  logic         start, started, commit, iend, ended, second_ended, timeout;
  logic [7:0]   cycle_cnt;
  logic [N-1:0] stage_tok;

  pipe_commit_monitor #(.NUM_STAGES(N), .CNT_W(8), .CNT_SAT(SAT), .MAX_CYCLES(MAX)) dut (
    .clk          (clk),
    .rst          (rst),
    .issue        (issue),
    .s1_accept    (s1_accept),
    .stall        (stall),
`ifdef PCM_FLUSH_EN
    .flush        (flush),
`endif
    .start        (start),
    .started      (started),
    .cycle_cnt    (cycle_cnt),
    .stage_tok    (stage_tok),
    .commit       (commit),
    .iend         (iend),
    .ended        (ended),
    .second_ended (second_ended),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         start;
    logic         started;
    logic [7:0]   cnt;
    logic [N-1:0] stage;
    logic         commit;
    logic         iend;
    logic         ended;
    logic         second;
    logic         timeout;
  } exp_t;

  exp_t q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state. m_pos = -1 means no token in a registered stage.
  logic m_start, m_started, m_commit, m_ended, m_second, m_timeout;
  int   m_cnt, m_pos;

  int cyc         = 0;
  int last_commit = -1;
  int n_commits   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_start = 0; m_started = 0; m_commit = 0; m_ended = 0; m_second = 0; m_timeout = 0;
    m_cnt = 0; m_pos = -1;
  endtask

  // One clock cycle: drive, predict, sample, compare, advance the model.
  task automatic step(input logic i_issue, input logic i_acc, input logic [N-1:0] i_stall,
                      input logic i_rst, input logic i_flush);
    exp_t e;
    exp_t g;
    logic fl;
    logic tok0;
    int   n_pos;
    logic n_commit;
    @(negedge clk);
    issue     = i_issue;
    s1_accept = i_acc;
    stall     = i_stall;
    rst       = i_rst;
`ifdef PCM_FLUSH_EN
    flush     = i_flush;
    fl        = i_flush;
`else
    fl        = 1'b0;
`endif
    tok0 = m_start & i_acc & ~fl;
    e.start   = m_start;
    e.started = m_started;
    e.cnt     = 8'(m_cnt);
    e.stage   = '0;
    e.stage[0] = tok0;
    if (m_pos >= 1) e.stage[m_pos] = 1'b1;
    e.commit  = m_commit;
    e.iend    = m_commit & m_started & ~m_ended & (m_cnt <= MAX);
    e.ended   = m_ended;
    e.second  = m_second;
    e.timeout = m_timeout;
    q.push_back(e);

    #2;
    g = q.pop_front();
    check("start",        32'(start),        32'(g.start));
    check("started",      32'(started),      32'(g.started));
    check("cycle_cnt",    32'(cycle_cnt),    32'(g.cnt));
    check("stage_tok",    32'(stage_tok),    32'(g.stage));
    check("commit",       32'(commit),       32'(g.commit));
    check("iend",         32'(iend),         32'(g.iend));
    check("ended",        32'(ended),        32'(g.ended));
    check("second_ended", 32'(second_ended), 32'(g.second));
    check("timeout",      32'(timeout),      32'(g.timeout));
    check("ended_and_timeout", 32'(ended & timeout), 32'd0);
    if (commit === 1'b1) begin
      last_commit = cyc;
      n_commits++;
    end

    if (i_rst) begin
      model_reset();
    end else begin
      n_pos    = m_pos;
      n_commit = 1'b0;
      if (fl) begin
        n_pos = -1;
      end else if (tok0) begin
        n_pos = i_stall[1] ? -1 : 1;
      end else if (m_pos >= 1) begin
        if (!i_stall[m_pos]) begin
          if (m_pos == N-1) begin
            n_pos    = -1;
            n_commit = 1'b1;
          end else begin
            n_pos = i_stall[m_pos+1] ? -1 : m_pos + 1;
          end
        end
      end
      m_timeout = m_timeout | (m_started & ~m_ended & (m_cnt > MAX));
      m_second  = m_second | (m_ended & m_commit & m_started & ~m_second);
      m_ended   = m_ended | e.iend;
      if ((m_start | m_started) && m_cnt < SAT) m_cnt = m_cnt + 1;
      m_started = m_started | m_start;
      m_start   = (m_start | m_started) ? 1'b0 : i_issue;
      m_pos     = n_pos;
      m_commit  = n_commit;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1, '0, 1'b1, 1'b0);
    n_commits   = 0;
    last_commit = -1;
  endtask

  int t0;

  initial begin
    rst = 1'b1; issue = 1'b0; s1_accept = 1'b1; stall = '0;
`ifdef PCM_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (2) @(posedge clk);
    model_reset();

    // Reset state and a plain pass through the pipeline.
    idle(2);
    check("reset_cnt", 32'(cycle_cnt), 32'd0);
    t0 = cyc;
    step(1'b1, 1'b1, '0, 1'b0, 1'b0);
    idle(10);
    check("nostall_latency", 32'(last_commit - t0), 32'd5);
    check("nostall_ended", 32'(ended), 32'd1);

    // Token held in S3 by three cycles of stall[2].
    do_reset();
    t0 = cyc;
    step(1'b1, 1'b1, '0, 1'b0, 1'b0);
    idle(2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'b0100, 1'b0, 1'b0);
    idle(6);
    check("stall_latency", 32'(last_commit - t0), 32'd8);
    check("stall_ended", 32'(ended), 32'd1);

    // Token held in S4 for 60 cycles: timeout, and the late commit is not an end.
    do_reset();
    step(1'b1, 1'b1, '0, 1'b0, 1'b0);
    idle(3);
    for (int i = 0; i < 60; i++) step(1'b0, 1'b1, 4'b1000, 1'b0, 1'b0);
    idle(4);
    check("late_commit_seen", 32'(n_commits), 32'd1);
    check("late_timeout", 32'(timeout), 32'd1);
    check("late_not_ended", 32'(ended), 32'd0);

    // Token refused at S1: no commit, timeout, counter saturates.
    do_reset();
    step(1'b1, 1'b1, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    idle(140);
    check("lost_no_commit", 32'(n_commits), 32'd0);
    check("lost_timeout", 32'(timeout), 32'd1);
    check("saturate_cnt", 32'(cycle_cnt), 32'd132);

    // Reset with the token in S2, then a fresh epoch.
    do_reset();
    step(1'b1, 1'b1, '0, 1'b0, 1'b0);
    idle(2);
    check("pre_rst_s2", 32'(stage_tok), 32'b0010);
    do_reset();
    idle(1);
    check("post_rst_tok", 32'(stage_tok), 32'd0);
    check("post_rst_started", 32'(started), 32'd0);
    t0 = cyc;
    step(1'b1, 1'b1, '0, 1'b0, 1'b0);
    idle(8);
    check("restart_latency", 32'(last_commit - t0), 32'd5);

`ifdef PCM_FLUSH_EN
    // Flush with the token in S3.
    do_reset();
    step(1'b1, 1'b1, '0, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 1'b1, '0, 1'b0, 1'b1);
    idle(1);
    check("flush_tok", 32'(stage_tok), 32'd0);
    check("flush_started", 32'(started), 32'd1);
    idle(8);
    check("flush_no_commit", 32'(n_commits), 32'd0);
`endif

    // Random stall / accept / flush traffic against the model.
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      step(1'b1, 1'b1, '0, 1'b0, 1'b0);
      for (int i = 0; i < 70; i++) begin
        logic [N-1:0] st;
        for (int b = 0; b < N; b++) st[b] = ($urandom_range(0, 3) == 0);
        step(($urandom_range(0, 1) == 1), ($urandom_range(0, 7) != 0), st, 1'b0,
             ($urandom_range(0, 31) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
